// File: rtl/skolem_chk_pkg.sv
// Shared types and helpers for the Skolem sweep checker: FSM state encoding,
// default widths and the signed comparison used by the formula evaluator.
package skolem_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int A_W_DEF = 4;
  localparam int VEC_W   = 2 * A_W_DEF;
  localparam int CNT_W   = VEC_W + 1;

  // Operands arrive already sign-extended to 32 bits, so one helper serves any A_W.
  function automatic logic slt_signed(input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/skolem_sweep_checker_spec_eval.sv
// Combinational evaluator of phi(a,b,y) = (a*zext(y)) mod 2^A_W <s b.
// A vector fails when some y satisfies phi but the supplied y does not.
module spec_eval
  import skolem_chk_pkg::*;
#(
  parameter int A_W = 4
) (
  input  logic [A_W-1:0] a_i,
  input  logic [A_W-1:0] b_i,
  input  logic           y_i,
  output logic           fail_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               phi0;
  logic               phi1;
  logic               phi_y;

  assign a_s = {{(32-A_W){a_i[A_W-1]}}, a_i};
  assign b_s = {{(32-A_W){b_i[A_W-1]}}, b_i};

  // y=0 zeroes the product, y=1 leaves a unchanged.
  assign phi0   = slt_signed(32'sd0, b_s);
  assign phi1   = slt_signed(a_s, b_s);
  assign phi_y  = y_i ? phi1 : phi0;
  assign fail_o = (phi0 | phi1) & ~phi_y;

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep of all 2^(2*A_W) input vectors of a Skolem function,
// counting failures and capturing the lowest failing vector.
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int A_W    = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [2*A_W-1:0] vec_o,
  input  logic             skolem_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*A_W:0]   fail_cnt,
  output logic             first_fail_valid,
  output logic [2*A_W-1:0] first_fail_vec,
  output state_t           dbg_state_o
);

  localparam int VW      = 2 * A_W;
  localparam int CW      = VW + 1;
  localparam int SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // DRIVE is the first settle cycle, so SETTLE holds the remaining SETTLE-1 cycles.
  localparam int SC_INIT = (SETTLE > 1) ? SETTLE - 2 : 0;

  state_t          state_q;
  logic [VW-1:0]   vec_q;
  logic [SC_W-1:0] cnt_q;
  logic            y_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [CW-1:0]   fail_cnt_q;
  logic [CW-1:0]   fail_cnt_d;
  logic            ffv_q;
  logic [VW-1:0]   ffvec_q;
  logic            vec_fail;
  logic            last_vec;

  spec_eval #(.A_W(A_W)) u_spec_eval (
    .a_i    (vec_q[A_W-1:0]),
    .b_i    (vec_q[VW-1:A_W]),
    .y_i    (y_q),
    .fail_o (vec_fail)
  );

  assign fail_cnt_d = fail_cnt_q + CW'(vec_fail);
  assign last_vec   = &vec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fail_cnt_q <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            pass_q     <= 1'b0;
            vec_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt_q <= SC_W'(SC_INIT);
          if (SETTLE <= 1) begin
            y_q     <= skolem_i;
            state_q <= ST_SAMPLE;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            y_q     <= skolem_i;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          fail_cnt_q <= fail_cnt_d;
          if (vec_fail && !ffv_q) begin
            ffv_q   <= 1'b1;
            ffvec_q <= vec_q;
          end
          if (last_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
            state_q <= ST_DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec_o            = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker: table-driven Skolem models against a reference
// built from the formula by direct enumeration over signed operands.
module tb_skolem_sweep_checker;
  import skolem_chk_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start3;
  logic       sk1, sk3;
  logic [7:0] vec1, vec3, ffvec1, ffvec3, d1, d2;
  logic       busy1, done1, pass1, ffv1;
  logic       busy3, done3, pass3, ffv3;
  logic [8:0] fcnt1, fcnt3;
  state_t     st1, st3;

  bit ytab [256];
  int checks = 0;
  int errors = 0;

  // Signed value of a 4-bit field, and the intended Skolem function y = a <s b.
  function automatic int sx(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  function automatic bit good_y(input logic [7:0] v);
    return sx(v[3:0]) < sx(v[7:4]);
  endfunction

  // SETTLE=1 instance sees a zero-delay table model; SETTLE=3 sees a 2-cycle delayed correct model.
  assign sk1 = ytab[vec1];
  always @(posedge clk) begin
    d1 <= vec3;
    d2 <= d1;
  end
  assign sk3 = good_y(d2);

  skolem_sweep_checker #(.A_W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_o(vec1), .skolem_i(sk1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fcnt1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .dbg_state_o(st1)
  );

  skolem_sweep_checker #(.A_W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec_o(vec3), .skolem_i(sk3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fcnt3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .dbg_state_o(st3)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate every (a,b), apply the formula to ytab, count failures.
  int         exp_cnt;
  bit         exp_ffv;
  logic [7:0] exp_ffvec;

  task automatic build_expected();
    exp_cnt = 0; exp_ffv = 0; exp_ffvec = '0;
    for (int b = -8; b <= 7; b++) begin
      for (int a = -8; a <= 7; a++) begin
        int v;
        bit phi0, phi1, ok;
        v    = ((b & 15) << 4) | (a & 15);
        phi0 = (0 < b);
        phi1 = (a < b);
        ok   = ytab[v] ? phi1 : phi0;
        if ((phi0 || phi1) && !ok) begin
          exp_cnt++;
          if (!exp_ffv || v < int'(exp_ffvec)) begin
            exp_ffv = 1;
            exp_ffvec = 8'(v);
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Cycle numbering: the edge sampling start ends cycle 0; the period after it is cycle 1.
  task automatic run_sweep1(input int start_again_at, output int done_cyc);
    int cyc;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 2000) begin
      start1 = (cyc == start_again_at);
      @(posedge clk); #1;
      cyc++;
    end
    start1   = 1'b0;
    done_cyc = done1 ? cyc : -1;
  endtask

  task automatic verify_sweep1(input string tag, input int done_cyc);
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(513));
    check({tag, "_fail_cnt"}, 64'(fcnt1), 64'(exp_cnt));
    check({tag, "_pass"}, 64'(pass1), 64'(exp_cnt == 0));
    check({tag, "_ffv"}, 64'(ffv1), 64'(exp_ffv));
    check({tag, "_ffvec"}, 64'(ffvec1), 64'(exp_ffvec));
    check({tag, "_busy_at_done"}, 64'(busy1), 64'(0));
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_done_pulse_low"}, 64'(done1), 64'(0));
    check({tag, "_cnt_held"}, 64'(fcnt1), 64'(exp_cnt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    for (int v = 0; v < 256; v++) ytab[v] = good_y(8'(v));
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", 64'(vec1), 64'(0));
    check("rst_busy", 64'(busy1), 64'(0));
    check("rst_done", 64'(done1), 64'(0));
    check("rst_pass", 64'(pass1), 64'(0));
    check("rst_fail_cnt", 64'(fcnt1), 64'(0));
    check("rst_ffv", 64'(ffv1), 64'(0));
    check("rst_ffvec", 64'(ffvec1), 64'(0));
    check("rst_busy3", 64'(busy3), 64'(0));
    rst = 1'b0;

    // correct Skolem function
    build_expected();
    run_sweep1(0, dc);
    verify_sweep1("correct", dc);
    check("correct_pass_one", 64'(pass1), 64'(1));

    // stuck at 0
    for (int v = 0; v < 256; v++) ytab[v] = 1'b0;
    build_expected();
    run_sweep1(0, dc);
    verify_sweep1("stuck0", dc);
    check("stuck0_cnt_36", 64'(fcnt1), 64'(36));
    check("stuck0_ffvec_08", 64'(ffvec1), 64'(8'h08));

    // stuck at 1
    for (int v = 0; v < 256; v++) ytab[v] = 1'b1;
    build_expected();
    run_sweep1(0, dc);
    verify_sweep1("stuck1", dc);
    check("stuck1_cnt_28", 64'(fcnt1), 64'(28));
    check("stuck1_ffvec_11", 64'(ffvec1), 64'(8'h11));

    // random Skolem tables
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 256; v++) ytab[v] = bit'($urandom_range(0, 1));
      build_expected();
      run_sweep1(0, dc);
      verify_sweep1($sformatf("rand%0d", r), dc);
    end

    // start re-pulsed mid-sweep must be ignored
    for (int v = 0; v < 256; v++) ytab[v] = good_y(8'(v));
    build_expected();
    run_sweep1(100, dc);
    verify_sweep1("restart_ignored", dc);

    // reset mid-sweep (with start also high: reset wins), then a clean sweep
    for (int v = 0; v < 256; v++) ytab[v] = 1'b0;
    build_expected();
    begin
      int cyc;
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      cyc = 1;
      while (cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("mid_busy_before_rst", 64'(busy1), 64'(1));
      rst = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start1 = 1'b0;
      check("abort_vec", 64'(vec1), 64'(0));
      check("abort_busy", 64'(busy1), 64'(0));
      check("abort_done", 64'(done1), 64'(0));
      check("abort_pass", 64'(pass1), 64'(0));
      check("abort_fail_cnt", 64'(fcnt1), 64'(0));
      check("abort_ffv", 64'(ffv1), 64'(0));
      check("abort_ffvec", 64'(ffvec1), 64'(0));
    end
    run_sweep1(0, dc);
    verify_sweep1("after_abort", dc);

    // SETTLE=3 with delayed correct model: 4 cycles per vector
    begin
      int cyc, since, bad, changes;
      logic [7:0] last;
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      cyc = 1; since = 1; bad = 0; changes = 0; last = vec3;
      while (!done3 && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
        if (vec3 !== last) begin
          if (since != 4) bad++;
          changes++;
          since = 1;
          last = vec3;
        end else begin
          since++;
        end
      end
      check("s3_done_cycle", 64'(done3 ? cyc : -1), 64'(1025));
      check("s3_fail_cnt", 64'(fcnt3), 64'(0));
      check("s3_pass", 64'(pass3), 64'(1));
      check("s3_ffv", 64'(ffv3), 64'(0));
      check("s3_hold_violations", 64'(bad), 64'(0));
      check("s3_vec_changes", 64'(changes), 64'(255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
